// File: rtl/sdram_host_adapter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_host_adapter
// Purpose  : Upstream front-end for the SDRAM controller. Host read/write
//            requests arrive over valid/ready and are queued in a small
//            command FIFO. Each request is then presented to the
//            controller's level-style host port. The controller's busy
//            output serves both as the acknowledge and as the completion
//            indication. Read data comes back to the host as a one-cycle
//            response pulse after a fixed capture delay.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1            system clock, rising edge
//   rst            in   1            synchronous reset, active-high
//   req_valid      in   1            host request valid
//   req_ready      out  1            command FIFO can accept (0 during init)
//   req_write      in   1            1 = write, 0 = read
//   req_addr       in   HADDR_WIDTH  word address
//   req_wdata      in   16           write data
//   rsp_valid      out  1            one-cycle read-data pulse
//   rsp_rdata      out  16           read data, valid with rsp_valid
//   retry_count    out  8            saturating count of ack timeouts
//   sd_haddr       out  HADDR_WIDTH  controller haddr
//   sd_data_input  out  16           controller data_input
//   sd_rd_enable   out  1            controller rd_enable
//   sd_wr_enable   out  1            controller wr_enable
//   sd_busy        in   1            controller busy
//   sd_data_output in   16           controller data_output
// ============================================================================
module sdram_host_adapter #(
  parameter int HADDR_WIDTH = 24,
  parameter int FIFO_DEPTH  = 4,
  parameter int INIT_CYCLES = 32,
  parameter int RD_LATENCY  = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [HADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]            req_wdata,
  output logic                   rsp_valid,
  output logic [15:0]            rsp_rdata,
  output logic [7:0]             retry_count,
  output logic [HADDR_WIDTH-1:0] sd_haddr,
  output logic [15:0]            sd_data_input,
  output logic                   sd_rd_enable,
  output logic                   sd_wr_enable,
  input  logic                   sd_busy,
  input  logic [15:0]            sd_data_output
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + HADDR_WIDTH + 16;
  localparam int DLY_MAX = (INIT_CYCLES > RD_LATENCY) ? INIT_CYCLES : RD_LATENCY;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam int TMO_W   = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_INIT_WAIT = 3'd0,
    S_IDLE      = 3'd1,
    S_ISSUE     = 3'd2,
    S_ACTIVE    = 3'd3,
    S_RD_WAIT   = 3'd4
  } state_e;

  // --------------------------------------------------------------------------
  // Command FIFO: entry = {write, addr, wdata}
  // --------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  state_e             state_q;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic               head_write;
  logic [HADDR_WIDTH-1:0] head_addr;
  logic [15:0]        head_wdata;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // The controller needs its init sequence before any traffic, so the host
  // is held off entirely until the init wait has expired.
  assign req_ready  = !fifo_full && (state_q != S_INIT_WAIT);
  assign push       = req_valid && req_ready;

  // Busy must be sampled low before a new request is started; this keeps
  // a fresh issue from overlapping the cycle in which busy falls.
  assign pop        = (state_q == S_IDLE) && !fifo_empty && !sd_busy;

  assign head       = mem_q[rd_ptr_q];
  assign head_write = head[ENTRY_W-1];
  assign head_addr  = head[16 +: HADDR_WIDTH];
  assign head_wdata = head[15:0];

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_write, req_addr, req_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Issue FSM with registered controller-side and response outputs
  // --------------------------------------------------------------------------
  logic [DLY_W-1:0]       dly_q;
  logic [TMO_W-1:0]       tmo_q;
  logic                   op_write_q;
  logic [HADDR_WIDTH-1:0] sd_haddr_q;
  logic [15:0]            sd_data_input_q;
  logic                   sd_rd_enable_q;
  logic                   sd_wr_enable_q;
  logic                   rsp_valid_q;
  logic [15:0]            rsp_rdata_q;
  logic [7:0]             retry_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_INIT_WAIT;
      dly_q           <= DLY_W'(INIT_CYCLES - 1);
      tmo_q           <= '0;
      op_write_q      <= 1'b0;
      sd_haddr_q      <= '0;
      sd_data_input_q <= '0;
      sd_rd_enable_q  <= 1'b0;
      sd_wr_enable_q  <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      retry_count_q   <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_INIT_WAIT: begin
          if (dly_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            dly_q <= dly_q - DLY_W'(1);
          end
        end

        S_IDLE: begin
          if (pop) begin
            // Address/data stay in these registers until the next pop.
            sd_haddr_q      <= head_addr;
            sd_data_input_q <= head_wdata;
            op_write_q      <= head_write;
            sd_rd_enable_q  <= !head_write;
            sd_wr_enable_q  <= head_write;
            tmo_q           <= '0;
            state_q         <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (sd_busy) begin
            sd_rd_enable_q <= 1'b0;
            sd_wr_enable_q <= 1'b0;
            state_q        <= S_ACTIVE;
          end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
            // Controller is likely refreshing: note it and keep holding
            // the enable; the request is never abandoned.
            tmo_q <= '0;
            if (retry_count_q != 8'hFF) begin
              retry_count_q <= retry_count_q + 8'd1;
            end
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        S_ACTIVE: begin
          if (!sd_busy) begin
            if (op_write_q) begin
              state_q <= S_IDLE;
            end else begin
              dly_q   <= DLY_W'(RD_LATENCY - 1);
              state_q <= S_RD_WAIT;
            end
          end
        end

        S_RD_WAIT: begin
          if (dly_q == '0) begin
            rsp_rdata_q <= sd_data_output;
            rsp_valid_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            dly_q <= dly_q - DLY_W'(1);
          end
        end

        default: begin
          state_q <= S_INIT_WAIT;
          dly_q   <= DLY_W'(INIT_CYCLES - 1);
        end
      endcase
    end
  end

  assign sd_haddr      = sd_haddr_q;
  assign sd_data_input = sd_data_input_q;
  assign sd_rd_enable  = sd_rd_enable_q;
  assign sd_wr_enable  = sd_wr_enable_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign retry_count   = retry_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_host_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_host_adapter
// Purpose  : Directed self-checking bench for sdram_host_adapter. The bench
//            plays the controller by driving sd_busy/sd_data_output by hand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_host_adapter;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [7:0]  retry_count;
  logic [23:0] sd_haddr;
  logic [15:0] sd_data_input;
  logic        sd_rd_enable;
  logic        sd_wr_enable;
  logic        sd_busy;
  logic [15:0] sd_data_output;

  int n_cmp  = 0;
  int n_fail = 0;

  sdram_host_adapter #(
    .HADDR_WIDTH(24),
    .FIFO_DEPTH (4),
    .INIT_CYCLES(32),
    .RD_LATENCY (4),
    .ACK_TIMEOUT(255)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .retry_count   (retry_count),
    .sd_haddr      (sd_haddr),
    .sd_data_input (sd_data_input),
    .sd_rd_enable  (sd_rd_enable),
    .sd_wr_enable  (sd_wr_enable),
    .sd_busy       (sd_busy),
    .sd_data_output(sd_data_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request and hold it until the FIFO takes it (bounded).
  task automatic push(input logic w, input logic [23:0] a, input logic [15:0] d);
    logic acc;
    int   n;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 600) begin
      acc = req_ready;
      step();
      n++;
    end
    chk("push_accepted", {31'd0, acc}, 32'd1);
    req_valid = 1'b0;
  endtask

  // Act as the controller for one request: wait for its enable, check the
  // presented command, ignore it for 'ignore' cycles, pulse busy once, and
  // for reads check the response timing and data.
  task automatic serve(input logic w, input logic [23:0] a, input logic [15:0] d,
                       input int ignore, input logic [15:0] rd);
    int   n;
    logic held;
    logic seen;
    sd_data_output = rd;
    n = 0;
    while (((w ? sd_wr_enable : sd_rd_enable) !== 1'b1) && n < 64) begin
      step();
      n++;
    end
    chk("enable_seen", {31'd0, (w ? sd_wr_enable : sd_rd_enable)}, 32'd1);
    chk("other_enable_low", {31'd0, (w ? sd_rd_enable : sd_wr_enable)}, 32'd0);
    chk("sd_haddr", {8'd0, sd_haddr}, {8'd0, a});
    if (w) chk("sd_data_input", {16'd0, sd_data_input}, {16'd0, d});
    held = 1'b1;
    for (int i = 0; i < ignore; i++) begin
      step();
      held &= ((w ? sd_wr_enable : sd_rd_enable) === 1'b1) &&
              ((w ? sd_rd_enable : sd_wr_enable) === 1'b0) && (sd_haddr === a);
    end
    chk("enable_held", {31'd0, held}, 32'd1);
    sd_busy = 1'b1;
    step();
    chk("enable_drop_on_busy", {30'd0, sd_rd_enable, sd_wr_enable}, 32'd0);
    sd_busy = 1'b0;
    step();
    if (!w) begin
      seen = rsp_valid;
      for (int i = 0; i < 3; i++) begin
        step();
        seen |= rsp_valid;
      end
      chk("rsp_not_early", {31'd0, seen}, 32'd0);
      step();
      chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, rd});
      step();
      chk("rsp_single_pulse", {31'd0, rsp_valid}, 32'd0);
    end else begin
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        step();
        seen |= rsp_valid;
      end
      chk("write_no_rsp", {31'd0, seen}, 32'd0);
    end
  endtask

  initial begin
    logic seen;
    rst            = 1'b1;
    req_valid      = 1'b0;
    req_write      = 1'b0;
    req_addr       = '0;
    req_wdata      = '0;
    sd_busy        = 1'b0;
    sd_data_output = '0;
    repeat (3) step();

    // Reset values
    chk("rst_req_ready",     {31'd0, req_ready},     32'd0);
    chk("rst_rsp_valid",     {31'd0, rsp_valid},     32'd0);
    chk("rst_rsp_rdata",     {16'd0, rsp_rdata},     32'd0);
    chk("rst_retry_count",   {24'd0, retry_count},   32'd0);
    chk("rst_sd_haddr",      {8'd0, sd_haddr},       32'd0);
    chk("rst_sd_data_input", {16'd0, sd_data_input}, 32'd0);
    chk("rst_sd_rd_enable",  {31'd0, sd_rd_enable},  32'd0);
    chk("rst_sd_wr_enable",  {31'd0, sd_wr_enable},  32'd0);

    // Init wait: host held off for 32 cycles even with a request pending
    rst       = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 24'h000123;
    req_wdata = 16'hBEEF;
    seen = 1'b0;
    for (int i = 0; i < 31; i++) begin
      step();
      seen |= req_ready | sd_wr_enable;
    end
    chk("init_ready_low", {31'd0, seen}, 32'd0);
    step();
    chk("init_done_ready", {31'd0, req_ready}, 32'd1);
    chk("init_no_wr_enable", {31'd0, sd_wr_enable}, 32'd0);
    step();
    req_valid = 1'b0;
    chk("no_wr_enable_at_push", {31'd0, sd_wr_enable}, 32'd0);

    // Single write
    serve(1'b1, 24'h000123, 16'hBEEF, 2, 16'h0000);

    // Single read with one-cycle busy
    push(1'b0, 24'h0A0001, 16'h0000);
    serve(1'b0, 24'h0A0001, 16'h0000, 0, 16'h5A5A);
    chk("retry_zero", {24'd0, retry_count}, 32'd0);

    // First request in flight while the controller ignores it (refresh);
    // the next four fill the FIFO.
    push(1'b1, 24'h000010, 16'h1111);
    push(1'b0, 24'h000020, 16'h0000);
    push(1'b1, 24'h000030, 16'h3333);
    push(1'b0, 24'h000040, 16'h0000);
    push(1'b1, 24'h000050, 16'h5555);
    chk("full_ready_low", {31'd0, req_ready}, 32'd0);
    serve(1'b1, 24'h000010, 16'h1111, 300, 16'h0000);
    chk("retry_after_refresh", {24'd0, retry_count}, 32'd1);
    chk("ready_after_pop", {31'd0, req_ready}, 32'd1);
    serve(1'b0, 24'h000020, 16'h0000, 1, 16'hA5C3);
    serve(1'b1, 24'h000030, 16'h3333, 1, 16'h0000);
    serve(1'b0, 24'h000040, 16'h0000, 1, 16'h0F0F);
    serve(1'b1, 24'h000050, 16'h5555, 1, 16'h0000);
    chk("retry_stable", {24'd0, retry_count}, 32'd1);

    // Reset during RD_WAIT with two entries queued
    push(1'b0, 24'h000777, 16'h0000);
    push(1'b0, 24'h000888, 16'h0000);
    push(1'b1, 24'h000999, 16'hABCD);
    chk("rd_in_flight", {31'd0, sd_rd_enable}, 32'd1);
    sd_data_output = 16'h1234;
    sd_busy = 1'b1;
    step();
    sd_busy = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid},    32'd0);
    chk("mid_rst_rd_enable", {31'd0, sd_rd_enable}, 32'd0);
    chk("mid_rst_req_ready", {31'd0, req_ready},    32'd0);
    chk("mid_rst_retry",     {24'd0, retry_count},  32'd0);
    chk("mid_rst_haddr",     {8'd0, sd_haddr},      32'd0);
    seen = 1'b0;
    for (int i = 0; i < 31; i++) begin
      step();
      seen |= req_ready;
    end
    chk("mid_rst_init_wait", {31'd0, seen}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen |= rsp_valid | sd_rd_enable | sd_wr_enable;
    end
    chk("mid_rst_fifo_empty", {31'd0, seen}, 32'd0);
    chk("mid_rst_ready_back", {31'd0, req_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
